// File: rtl/memory_top.sv
// Memory stage: req/ack data-memory bus with lane steering, load extraction,
// bounded-wait abort and the M/W pipeline register.
module memory_top #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [2:0]            MemoryOpM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [ADDR_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic [3:0]            MemStrb,
    output logic                  StallM,
    output logic                  BusErr,
    output logic                  MisalignErr,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [ADDR_WIDTH-1:0] RdW,
    output logic [DATA_WIDTH-1:0] PCPlus4W
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic        r_load;

    logic        w_access;
    logic        w_misalign;
    logic        w_start;
    logic        w_last;
    logic        w_stall;
    logic [1:0]  w_off;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        case (op[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] op, input logic [1:0] off,
                                                input logic store);
        logic [3:0] strb;
        case (op[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
        return store ? strb : 4'b0000;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] d;
        case (op[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                                 input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] d;
        sh = rd >> {off, 3'b000};
        case (op[1:0])
            2'b00:   d = op[2] ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   d = op[2] ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
            default: d = rd;
        endcase
        return d;
    endfunction

    assign w_off      = ALUResultM[1:0];
    assign w_access   = MemWriteM | (ResultSrcM == 2'b01);
    assign w_misalign = is_misaligned(MemoryOpM, w_off);
    assign w_start    = (r_state == S_IDLE) & w_access & ~w_misalign;
    assign w_last     = (r_cnt == CNT_LAST);
    assign StallM     = w_stall;

    // Stall: held through the launch cycle and every unacknowledged REQ cycle but the last.
    always_comb begin
        w_stall = 1'b0;
        if (!reset) begin
            w_stall = 1'b0;
        end else if (r_state == S_IDLE) begin
            w_stall = w_start;
        end else begin
            w_stall = ~MemAck & ~w_last;
        end
    end

    // Bus FSM, wait counter, sticky flags and the M/W register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_op        <= 3'b000;
            r_off       <= 2'b00;
            r_load      <= 1'b0;
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= 32'h0;
            MemWData    <= 32'h0;
            MemStrb     <= 4'b0000;
            BusErr      <= 1'b0;
            MisalignErr <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            ALUResultW  <= 32'h0;
            ReadDataW   <= 32'h0;
            RdW         <= '0;
            PCPlus4W    <= 32'h0;
        end else begin
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            case (r_state)
                S_IDLE: begin
                    r_cnt     <= 8'd0;
                    ReadDataW <= 32'h0;
                    if (w_start) begin
                        r_state   <= S_REQ;
                        r_op      <= MemoryOpM;
                        r_off     <= w_off;
                        r_load    <= ~MemWriteM;
                        MemReq    <= 1'b1;
                        MemWe     <= MemWriteM;
                        MemAddr   <= {ALUResultM[31:2], 2'b00};
                        MemWData  <= store_lanes(MemoryOpM, WriteDataM);
                        MemStrb   <= store_strobe(MemoryOpM, w_off, MemWriteM);
                        RegWriteW <= 1'b0;
                    end else begin
                        MemReq    <= 1'b0;
                        RegWriteW <= RegWriteM & ~(w_access & w_misalign);
                        if (w_access & w_misalign) begin
                            MisalignErr <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (MemAck) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 8'd0;
                        MemReq    <= 1'b0;
                        RegWriteW <= RegWriteM;
                        ReadDataW <= r_load ? load_extract(r_op, r_off, MemRData) : 32'h0;
                    end else if (w_last) begin
                        // Abort: retire the instruction without a register write.
                        r_state   <= S_IDLE;
                        r_cnt     <= 8'd0;
                        MemReq    <= 1'b0;
                        BusErr    <= 1'b1;
                        RegWriteW <= 1'b0;
                        ReadDataW <= 32'h0;
                    end else begin
                        r_cnt     <= r_cnt + 8'd1;
                        RegWriteW <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= 8'd0;
                    MemReq    <= 1'b0;
                    RegWriteW <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_top.sv
// Directed bench for memory_top: loads, stores, misalignment, timeout abort
// and reset in the middle of a bus transaction.
module tb_memory_top;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  MemoryOpM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemStrb;
    logic        StallM;
    logic        BusErr;
    logic        MisalignErr;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;

    int n_vec = 0;
    int n_err = 0;

    // values captured by run_access
    int          stall_cnt;
    logic        idle_req;
    logic        prev_rw;
    logic [31:0] prev_rdata;
    logic [31:0] prev_alu;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_strb;
    logic        b_we;
    logic        stable;
    logic        req_ok;
    int          req_cnt;
    logic        aborted;

    memory_top #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .MemoryOpM(MemoryOpM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M), .MemAck(MemAck), .MemRData(MemRData),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemStrb(MemStrb), .StallM(StallM), .BusErr(BusErr), .MisalignErr(MisalignErr),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_instr(input logic rw, input logic [1:0] rs, input logic mw,
                               input logic [2:0] op, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [4:0] rd,
                               input logic [31:0] pc);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        MemoryOpM  = op;
        ALUResultM = alu;
        WriteDataM = wd;
        RdM        = rd;
        PCPlus4M   = pc;
    endtask

    task automatic nop(input logic [31:0] alu, input logic [4:0] rd);
        drive_instr(1'b1, 2'b00, 1'b0, 3'b000, alu, 32'h0, rd, 32'h0);
    endtask

    // Runs an already-driven access: IDLE cycle, `waits` unacked REQ cycles, one acked cycle.
    task automatic run_access(input int waits, input logic [31:0] rdata);
        logic first;
        first  = 1'b1;
        stable = 1'b1;
        req_ok = 1'b1;
        @(negedge clk);
        stall_cnt  = int'(StallM);
        idle_req   = MemReq;
        prev_rw    = RegWriteW;
        prev_rdata = ReadDataW;
        prev_alu   = ALUResultW;
        @(posedge clk); #1;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                MemAck   = 1'b1;
                MemRData = rdata;
            end
            @(negedge clk);
            stall_cnt += int'(StallM);
            if (!MemReq) req_ok = 1'b0;
            if (first) begin
                b_addr  = MemAddr;
                b_wdata = MemWData;
                b_strb  = MemStrb;
                b_we    = MemWe;
                first   = 1'b0;
            end else if (MemAddr !== b_addr || MemWData !== b_wdata ||
                         MemStrb !== b_strb || MemWe !== b_we) begin
                stable = 1'b0;
            end
            @(posedge clk); #1;
        end
        MemAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        MemAck   = 1'b0;
        MemRData = 32'h0;
        drive_instr(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'h104);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", StallM, 0);
        check_eq("rst_req", MemReq, 0);
        check_eq("rst_we", MemWe, 0);
        check_eq("rst_addr", MemAddr, 0);
        check_eq("rst_regw", RegWriteW, 0);
        check_eq("rst_buserr", BusErr, 0);
        check_eq("rst_mis", MisalignErr, 0);

        // LW 0x100, ack on first REQ cycle
        @(posedge clk); #1;
        reset = 1'b1;
        run_access(0, 32'hDEADBEEF);
        check_eq("lw_stalls", stall_cnt, 1);
        check_eq("lw_addr", b_addr, 32'h100);
        check_eq("lw_strb", b_strb, 0);
        check_eq("lw_we", b_we, 0);
        check_eq("lw_req", req_ok, 1);
        nop(32'h55, 5'd7);
        @(negedge clk);
        check_eq("lw_rdata", ReadDataW, 32'hDEADBEEF);
        check_eq("lw_regw", RegWriteW, 1);
        check_eq("lw_rd", RdW, 5);
        check_eq("lw_pc", PCPlus4W, 32'h104);
        check_eq("lw_reqdrop", MemReq, 0);
        check_eq("nop_nostall", StallM, 0);

        // LB then LBU back-to-back
        @(posedge clk); #1;
        drive_instr(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 5'd8, 32'h0);
        run_access(0, 32'h80FFFFFF);
        check_eq("nop_alu", prev_alu, 32'h55);
        check_eq("nop_regw", prev_rw, 1);
        drive_instr(1'b1, 2'b01, 1'b0, 3'b100, 32'h103, 32'h0, 5'd9, 32'h0);
        run_access(0, 32'h80FFFFFF);
        check_eq("b2b_gap", idle_req, 0);
        check_eq("lb_sext", prev_rdata, 32'hFFFFFF80);

        // SH 0x1234ABCD to 0x202 with two wait cycles
        drive_instr(1'b0, 2'b00, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 32'h0);
        run_access(2, 32'h0);
        check_eq("lbu_zext", prev_rdata, 32'h00000080);
        check_eq("sh_stalls", stall_cnt, 3);
        check_eq("sh_addr", b_addr, 32'h200);
        check_eq("sh_strb", b_strb, 4'b1100);
        check_eq("sh_wdata", b_wdata, 32'hABCDABCD);
        check_eq("sh_we", b_we, 1);
        check_eq("sh_stable", stable, 1);
        check_eq("sh_req", req_ok, 1);

        // SB 0x77 to 0x301
        drive_instr(1'b0, 2'b00, 1'b1, 3'b000, 32'h301, 32'hAAAA5577, 5'd0, 32'h0);
        run_access(0, 32'h0);
        check_eq("sb_addr", b_addr, 32'h300);
        check_eq("sb_strb", b_strb, 4'b0010);
        check_eq("sb_wdata", b_wdata, 32'h77777777);

        // LH at 0x101: misaligned
        drive_instr(1'b1, 2'b01, 1'b0, 3'b001, 32'h101, 32'h0, 5'd10, 32'h0);
        @(negedge clk);
        check_eq("mis_stall", StallM, 0);
        check_eq("mis_req", MemReq, 0);
        @(posedge clk); #1;
        nop(32'h77, 5'd11);
        @(negedge clk);
        check_eq("mis_flag", MisalignErr, 1);
        check_eq("mis_regw", RegWriteW, 0);
        check_eq("mis_rd", RdW, 10);
        check_eq("mis_req2", MemReq, 0);
        check_eq("pre_to_buserr", BusErr, 0);

        // LW with no ack: timeout
        @(posedge clk); #1;
        drive_instr(1'b1, 2'b01, 1'b0, 3'b010, 32'h400, 32'h0, 5'd12, 32'h0);
        req_cnt = 0;
        aborted = 1'b0;
        @(negedge clk);
        stall_cnt = int'(StallM);
        @(posedge clk); #1;
        for (int i = 0; i < 40 && !aborted; i++) begin
            @(negedge clk);
            if (MemReq) req_cnt++;
            if (StallM) stall_cnt++;
            if (MemReq && !StallM) aborted = 1'b1;
            @(posedge clk); #1;
        end
        nop(32'h88, 5'd13);
        check_eq("to_abort", aborted, 1);
        check_eq("to_req_cycles", req_cnt, 16);
        check_eq("to_stalls", stall_cnt, 16);
        @(negedge clk);
        check_eq("to_buserr", BusErr, 1);
        check_eq("to_regw", RegWriteW, 0);
        check_eq("to_rdata", ReadDataW, 0);
        check_eq("to_req", MemReq, 0);
        check_eq("to_stall", StallM, 0);

        // Reset in third REQ cycle, ack the cycle after
        @(posedge clk); #1;
        drive_instr(1'b1, 2'b01, 1'b0, 3'b010, 32'h500, 32'h0, 5'd14, 32'h504);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_stall", StallM, 0);
        @(posedge clk); #1;
        reset    = 1'b1;
        MemAck   = 1'b1;
        MemRData = 32'hCAFEF00D;
        nop(32'h66, 5'd15);
        @(negedge clk);
        check_eq("mid_rst_req", MemReq, 0);
        check_eq("mid_rst_addr", MemAddr, 0);
        check_eq("mid_rst_wdata", MemWData, 0);
        check_eq("mid_rst_regw", RegWriteW, 0);
        check_eq("mid_rst_rdata", ReadDataW, 0);
        check_eq("mid_rst_alu", ALUResultW, 0);
        check_eq("mid_rst_rd", RdW, 0);
        check_eq("mid_rst_pc", PCPlus4W, 0);
        check_eq("mid_rst_buserr", BusErr, 0);
        check_eq("mid_rst_mis", MisalignErr, 0);
        @(posedge clk); #1;
        MemAck = 1'b0;
        @(negedge clk);
        check_eq("ack_ignored", ReadDataW, 0);
        check_eq("post_rst_regw", RegWriteW, 1);
        check_eq("post_rst_alu", ALUResultW, 32'h66);
        check_eq("post_rst_req", MemReq, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_top.md
# memory_top

Memory stage of the 5-stage pipeline. Consumes the execute-stage outputs (M-side controls, ALU result, store data), performs loads and stores over a registered req/ack data-memory bus, and produces the M/W pipeline register for writeback. Generates `StallM` to freeze upstream stages while a bus transaction is outstanding. Aborts a transaction with a sticky error flag after a bounded wait.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath and bus width; only 32 is supported.
- `ADDR_WIDTH`, 5, register index width.
- `TIMEOUT`, 16, maximum REQ cycles before abort; range 2..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `RegWriteM`  in  1  register write enable of the M instruction.
- `ResultSrcM`  in  2  writeback source: 00 ALU, 01 load, 10 PC+4.
- `MemWriteM`  in  1  store.
- `MemoryOpM`  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ALUResultM`  in  32  effective address, or the ALU result.
- `WriteDataM`  in  32  store data, unaligned (low bits).
- `RdM`  in  5  destination register.
- `PCPlus4M`  in  32  return address.
- `MemAck`  in  1  bus acknowledge; read data is valid in the same cycle.
- `MemRData`  in  32  bus read word.
- `MemReq`  out  1  bus request (registered).
- `MemWe`  out  1  bus write (registered).
- `MemAddr`  out  32  word-aligned address, low 2 bits = 0 (registered).
- `MemWData`  out  32  lane-aligned store data (registered).
- `MemStrb`  out  4  byte strobes (registered).
- `StallM`  out  1  freeze the F/D/E pipeline registers.
- `BusErr`  out  1  sticky: a transaction timed out.
- `MisalignErr`  out  1  sticky: a misaligned access was suppressed.
- `RegWriteW`, `ResultSrcW`, `ALUResultW`, `ReadDataW`, `RdW`, `PCPlus4W`  out  1/2/32/32/5/32  M/W register outputs.

## Operation
- Access = `MemWriteM` | (`ResultSrcM`==01). Offset `off` = `ALUResultM[1:0]`.
- Misaligned: H/HU with `off[0]`=1, or W with `off`≠0.
  - No bus activity and no stall.
  - `MisalignErr` is set.
  - The instruction passes to W with `RegWriteW`=0.
- Store lane rules:
  - SB: `MemWData` = byte replicated to all lanes; `MemStrb` = 0001<<off.
  - SH: `MemWData` = half replicated; `MemStrb` = 0011<<off.
  - SW: `MemWData` = the word; `MemStrb` = 1111.
  - Loads drive `MemStrb` = 0000.
- Load extract: select the byte or half at `off` from `MemRData`. Sign-extend for B/H; zero-extend for BU/HU; W passes through.
- FSM, state IDLE:
  - On an aligned access: register `MemAddr`/`MemWData`/`MemStrb`/`MemWe`, set `MemReq`=1 next cycle, go to REQ, and assert `StallM`=1.
  - Otherwise `StallM`=0.
- FSM, state REQ: `StallM` = ~`MemAck`; the wait counter increments each cycle without an ack.
  - `MemAck`=1: the W register loads (with extracted `ReadDataW` for loads), `MemReq` drops next edge, go to IDLE.
  - Counter reaches `TIMEOUT`-1 without an ack: abort. `MemReq` drops, `BusErr` is set, `StallM`=0 that cycle, W loads with `RegWriteW`=0 and `ReadDataW`=0, go to IDLE.
- `MemAck` while in IDLE is ignored.
- While `StallM`=1, the W register loads a bubble (`RegWriteW`=0; other fields don't-care).
- Sticky flags clear only on reset.

## Timing
- Non-memory instruction: 1-cycle M→W, no stall.
- Memory access: minimum 2 cycles. IDLE cycle (stall) + REQ cycle with ack (no stall); one stall cycle total.
- Each additional wait cycle adds one stall cycle. Worst case `TIMEOUT` stall cycles.
- Back-to-back accesses:
  - `MemReq` is low for exactly one cycle between them (the IDLE cycle).
  - Bus outputs are stable throughout REQ.
- Reset (`reset`=0 at an edge), including mid-REQ, clears all of the following:
  - FSM → IDLE, counter 0.
  - `MemReq`, `MemWe`, `MemStrb`, `MemAddr`, `MemWData` → 0.
  - All W outputs → 0, `BusErr`/`MisalignErr` → 0.
  - `StallM` is 0 during reset.
  - An outstanding ack is dropped.

## Test plan
- LW from 0x100, `MemAck` on the first REQ cycle, `MemRData`=0xDEADBEEF -> `StallM` high for 1 cycle, `MemAddr`=0x100, `ReadDataW`=0xDEADBEEF, `RegWriteW`=1.
- LB from 0x103 with `MemRData`=0x80FFFFFF -> `ReadDataW`=0xFFFFFF80; the same access as LBU -> 0x00000080.
- SH 0x1234ABCD to 0x202 -> `MemAddr`=0x200, `MemStrb`=1100, `MemWData`=0xABCDABCD, `MemWe`=1.
- LW with no ack, `TIMEOUT`=16 -> `MemReq` high for 16 cycles, then `BusErr`=1, `RegWriteW`=0, `StallM` drops.
- LH at 0x101 -> no `MemReq`, no stall, `MisalignErr`=1, `RegWriteW`=0.
- Reset asserted in the 3rd REQ cycle, with ack arriving the following cycle -> `MemReq`=0 after the edge, W outputs all 0, the ack is ignored.
